// File: rtl/booth_r4_seq_mult_pkg.sv
// booth_r4_seq_mult_pkg: FSM states, Booth digit encoding and radix-4 digit decoder.
package booth_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} booth_state_t;
   typedef enum logic [2:0] {B_ZERO, B_P1, B_P2, B_M1, B_M2} booth_digit_t;
   function automatic booth_digit_t booth_r4_decode(input logic [2:0] bits);
      return (bits == 3'b001 || bits == 3'b010) ? B_P1 :
             (bits == 3'b011)                   ? B_P2 :
             (bits == 3'b100)                   ? B_M2 :
             (bits == 3'b101 || bits == 3'b110) ? B_M1 : B_ZERO;
   endfunction
endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// booth_r4_seq_mult_if: operand and result valid/ready channels of the Booth multiplier.
interface booth_r4_seq_mult_if #(parameter int WIDTH = 16);
   logic               in_valid, in_ready, is_signed, out_valid, out_ready;
   logic [WIDTH-1:0]   a, b;
   logic [2*WIDTH-1:0] result;
   modport master(output in_valid, a, b, is_signed, out_ready, input in_ready, out_valid, result);
   modport slave(input in_valid, a, b, is_signed, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/booth_r4_seq_mult_pp.sv
// booth_r4_pp: selects 0/+-M/+-2M; negation is ~x here with the +1 returned as the adder carry-in.
module booth_r4_pp
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  booth_digit_t       digit,
   input  logic [WIDTH+1:0]   m,
   output logic [WIDTH+3:0]   addend,
   output logic               cin
);
   logic [WIDTH+3:0] mx, sel;
   always_comb begin
      mx     = {{2{m[WIDTH+1]}}, m};
      sel    = (digit == B_P2 || digit == B_M2) ? mx << 1 : (digit == B_ZERO) ? '0 : mx;
      cin    = digit == B_M1 || digit == B_M2;
      addend = cin ? ~sel : sel;
   end
endmodule

// File: rtl/booth_r4_seq_mult.sv
// booth_r4_seq_mult: sequential radix-4 Booth multiplier, signed or unsigned per transaction.
module booth_r4_seq_mult
   import booth_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic                clk,
   input logic                rst_n,
   booth_r4_seq_mult_if.slave bus
);
   localparam int NITER = WIDTH / 2 + 1;
   localparam int EW    = WIDTH + 2;
   localparam int AW    = WIDTH + 4;
   localparam int CW    = $clog2(NITER) + 1;
   if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
      $error("booth_r4_seq_mult: WIDTH must be even and >= 4");
   end
   booth_state_t  state;
   booth_digit_t  digit;
   logic [AW-1:0] acc, acc_n, sum, addend;
   logic [EW-1:0] mcand, mplier, mplier_n;
   logic [CW-1:0] cnt;
   logic          prev, cin;
   booth_r4_pp #(.WIDTH(WIDTH)) u_pp (.digit(digit), .m(mcand), .addend(addend), .cin(cin));
   // {acc, mplier} shifts right as one arithmetic register; prev carries the b[2i-1] bit.
   always_comb begin
      digit    = booth_r4_decode({mplier[1:0], prev});
      sum      = acc + addend + AW'(cin);
      acc_n    = {{2{sum[AW-1]}}, sum[AW-1:2]};
      mplier_n = {sum[1:0], mplier[EW-1:2]};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.result    <= '0;
         cnt           <= '0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         prev          <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid && bus.in_ready) begin
               mcand        <= {{2{bus.is_signed & bus.a[WIDTH-1]}}, bus.a};
               mplier       <= {{2{bus.is_signed & bus.b[WIDTH-1]}}, bus.b};
               acc          <= '0;
               prev         <= 1'b0;
               cnt          <= '0;
               bus.in_ready <= 1'b0;
               state        <= RUN;
            end
            RUN: begin
               acc    <= acc_n;
               mplier <= mplier_n;
               prev   <= mplier[1];
               cnt    <= cnt + CW'(1);
               if (cnt == CW'(NITER - 1)) begin
                  bus.result    <= {acc_n[WIDTH-3:0], mplier_n};
                  bus.out_valid <= 1'b1;
                  state         <= DONE;
               end
            end
            DONE: if (bus.out_ready) begin
               bus.out_valid <= 1'b0;
               bus.in_ready  <= 1'b1;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb_booth_r4_seq_mult: directed vectors, handshake/reset corner cases and random products at WIDTH 16 and 8.
module tb_booth_r4_seq_mult;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   booth_r4_seq_mult_if #(.WIDTH(16)) bus ();
   booth_r4_seq_mult_if #(.WIDTH(8))  bus8 ();
   booth_r4_seq_mult #(.WIDTH(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
   booth_r4_seq_mult #(.WIDTH(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[10];
   int   n_pass = 0, n_total = 0;
   bit   go8 = 1'b0, done8 = 1'b0;
   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endfunction
   task automatic start(input logic [15:0] a, input logic [15:0] b, input logic s);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.is_signed = s; bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask
   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic consume();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
   endtask
   initial begin
      int lat, errs;
      logic [15:0] ra, rb;
      logic        rs;
      logic [31:0] re;
      logic signed [31:0] rse;
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;
      vecs = '{'{16'h0003, 16'h0005, 1'b0, 32'd15},
               '{16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001},
               '{16'h8000, 16'h8000, 1'b1, 32'h4000_0000},
               '{16'h8000, 16'h0001, 1'b1, 32'hFFFF_8000},
               '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001},
               '{16'h0000, 16'hABCD, 1'b0, 32'h0000_0000},
               '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF_0001},
               '{16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000},
               '{16'hFFFF, 16'h0002, 1'b1, 32'hFFFF_FFFE},
               '{16'hFFFF, 16'h0002, 1'b0, 32'h0001_FFFE}};
      #12;
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_result", bus.result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         start(vecs[i].a, vecs[i].b, vecs[i].s);
         wait_done(lat);
         chk($sformatf("vec%0d_result", i), bus.result, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, 32'd9);
         consume();
      end
      // result, out_valid and in_ready must hold under 20 cycles of backpressure
      start(16'd3, 16'd7, 1'b0);
      wait_done(lat);
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b1 || bus.result !== 32'd21 || bus.in_ready !== 1'b0) errs++;
      end
      chk("bp_hold_errors", errs, 32'd0);
      consume();
      chk("bp_out_valid_after", {31'b0, bus.out_valid}, 32'd0);
      chk("bp_in_ready_after", {31'b0, bus.in_ready}, 32'd1);
      // new operands mid-RUN are ignored; out_ready already high consumes on first valid cycle
      bus.out_ready = 1'b1;
      start(16'd100, 16'd200, 1'b0);
      repeat (3) @(negedge clk);
      bus.a = 16'd5; bus.b = 16'hFFFB; bus.is_signed = 1'b1; bus.in_valid = 1'b1;
      @(negedge clk) bus.in_valid = 1'b0;
      wait_done(lat);
      chk("busy_result", bus.result, 32'd20000);
      @(negedge clk);
      chk("early_ready_consumed", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b0;
      start(16'h1234, 16'h5678, 1'b0);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_run_in_ready", {31'b0, bus.in_ready}, 32'd1);
      chk("rst_run_out_valid", {31'b0, bus.out_valid}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      start(16'd9, 16'd9, 1'b0);
      wait_done(lat);
      chk("pre_rst_done_valid", {31'b0, bus.out_valid}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_done_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("rst_done_result", bus.result, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      start(16'h1234, 16'h5678, 1'b0);
      wait_done(lat);
      chk("post_rst_result", bus.result, 32'h0626_0060);
      consume();
      for (int i = 0; i < 300; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
         if (rs) begin
            rse = $signed(ra) * $signed(rb);
            re  = rse;
         end else re = ra * rb;
         start(ra, rb, rs);
         wait_done(lat);
         chk($sformatf("rnd16_%0d a=%h b=%h s=%0d", i, ra, rb, rs), bus.result, re);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         consume();
      end
      go8 = 1'b1;
      wait (done8);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
   initial begin
      int lat8;
      logic [7:0]  a8, b8;
      logic        s8;
      logic [15:0] e8;
      logic signed [15:0] se8;
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.is_signed = 1'b0; bus8.out_ready = 1'b0;
      wait (go8);
      for (int i = 0; i < 200; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
         if (i == 0) begin a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; end
         if (i == 1) begin a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; end
         if (s8) begin
            se8 = $signed(a8) * $signed(b8);
            e8  = se8;
         end else e8 = a8 * b8;
         @(negedge clk);
         bus8.a = a8; bus8.b = b8; bus8.is_signed = s8; bus8.in_valid = 1'b1;
         @(negedge clk);
         bus8.in_valid = 1'b0;
         lat8 = 0;
         while (!bus8.out_valid && lat8 < 40) begin
            @(negedge clk);
            lat8++;
         end
         chk($sformatf("rnd8_%0d a=%h b=%h s=%0d", i, a8, b8, s8), {16'b0, bus8.result}, {16'b0, e8});
         repeat ($urandom_range(0, 2)) @(negedge clk);
         bus8.out_ready = 1'b1;
         @(negedge clk);
         bus8.out_ready = 1'b0;
      end
      done8 = 1'b1;
   end
endmodule
